// File: rtl/wisc_mem_pkg.sv
// Shared types for the memory arbiter: FSM states, grant encoding and
// the default WAIT timeout.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin chooser: on a conflict it grants the port that was
// not granted last; otherwise it grants whichever port is requesting.
module rr_arb2
  import wisc_mem_pkg::*;
(
  input  logic [1:0] req,   // bit 0 = instruction port, bit 1 = data port
  input  grant_t     last,
  output grant_t     gnt
);

  always_comb begin
    gnt = GNT_I;
    if (req == 2'b11) begin
      gnt = (last == GNT_I) ? GNT_D : GNT_I;
    end else if (req[1]) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory backend, one transaction at a time, with a WAIT timeout.
module mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output state_t            dbg_state
);

  // Handshakes: a port holds req (and its address/data) until it sees its
  // one-cycle done; a backend command is accepted on a cycle with mem_rd or
  // mem_wr high and mem_stall low; mem_done is only honoured in WAIT.

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  grant_t            gnt_sel, cur_gnt, last_grant;
  logic              cur_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              take, complete, timeout;

  rr_arb2 u_rr (
    .req  ({d_req, i_req}),
    .last (last_grant),
    .gnt  (gnt_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          take     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd    = ~cur_wr;
        mem_wr    = cur_wr;
        mem_addr  = lat_addr;
        mem_wdata = cur_wr ? lat_wdata : '0;
        if (!mem_stall) state_nx = WAIT;
      end
      WAIT: begin
        // A response in the final allowed cycle still beats the timeout.
        if (mem_done) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_gnt    <= GNT_I;
      last_grant <= GNT_I;
      cur_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;

      if (take) begin
        cur_gnt   <= gnt_sel;
        cur_wr    <= (gnt_sel == GNT_D) && d_wr;
        lat_addr  <= (gnt_sel == GNT_D) ? d_addr : i_addr;
        lat_wdata <= (gnt_sel == GNT_D) ? d_wdata : '0;
      end

      if (state == ISSUE && !mem_stall) cnt <= '0;
      else if (state == WAIT)           cnt <= cnt + CNT_W'(1);

      if (complete || timeout) begin
        last_grant <= cur_gnt;
        err        <= timeout;
        if (cur_gnt == GNT_I) begin
          i_done  <= 1'b1;
          i_rdata <= complete ? mem_rdata : '0;
        end else begin
          d_done  <= 1'b1;
          d_rdata <= (complete && !cur_wr) ? mem_rdata : '0;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before abort.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have these instruction-port signals: i_req  input  1  fetch request, held until i_done; i_addr  input  ADDR_W  fetch address; i_done  output  1  one-cycle completion pulse; i_rdata  output  DATA_W  fetched word, valid with i_done.
REQ-006 SHALL have these data-port signals: d_req  input  1  load/store request, held until d_done; d_wr  input  1  1=store, 0=load; d_addr  input  ADDR_W  data address; d_wdata  input  DATA_W  store data; d_done  output  1  one-cycle completion pulse; d_rdata  output  DATA_W  load data, valid with d_done.
REQ-007 SHALL have these memory-backend signals: mem_rd  output  1  read command; mem_wr  output  1  write command; mem_addr  output  ADDR_W  command address; mem_wdata  output  DATA_W  write data; mem_stall  input  1  backend cannot accept a command this cycle; mem_done  input  1  one-cycle completion from backend; mem_rdata  input  DATA_W  read data, valid with mem_done.
REQ-008 SHALL have err  output  1  one-cycle pulse when a transaction times out.

Function
REQ-009 SHALL implement an FSM with states IDLE, ISSUE, WAIT.
REQ-010 In IDLE with no request pending, the FSM SHALL stay in IDLE and drive all outputs to 0.
REQ-011 In IDLE with exactly one of i_req/d_req high, the FSM SHALL grant that port, latch its address, write data and type, and go to ISSUE at the next edge.
REQ-012 In IDLE with both requests high, the FSM SHALL grant the port not granted last (round-robin, using a last_grant flop).
REQ-013 In ISSUE, the block SHALL drive mem_rd (load/fetch) or mem_wr (store), with mem_addr and mem_wdata taken from the latched values.
REQ-014 ISSUE SHALL persist while mem_stall=1; the command is accepted in the first ISSUE cycle with mem_stall=0, and the FSM then goes to WAIT.
REQ-015 mem_rd and mem_wr SHALL never be high together, and SHALL be 0 outside ISSUE.
REQ-016 In WAIT, on mem_done=1, the block SHALL register mem_rdata into the granted port's rdata, pulse that port's done for exactly one cycle (the cycle after mem_done), update last_grant, and return to IDLE.
REQ-017 A store SHALL complete by pulsing d_done with d_rdata=0.
REQ-018 mem_done outside WAIT SHALL be ignored.
REQ-019 Minimum latency, with no stall and mem_done one cycle after the command: req sampled at edge N, command in cycle N+1, mem_done in cycle N+2, done pulse in cycle N+3.
REQ-020 There SHALL be one idle cycle between back-to-back grants; a new grant is evaluated only in IDLE.
REQ-021 A WAIT cycle counter SHALL reset on entry to WAIT; when it reaches TIMEOUT without mem_done, the block SHALL pulse err together with the granted port's done (rdata=0), update last_grant, and return to IDLE.
REQ-022 If mem_done arrives in the same cycle the counter reaches TIMEOUT, mem_done SHALL win and err stays 0.
REQ-023 Deasserting a request after it is granted SHALL NOT abort the transaction; done still pulses.
REQ-024 The non-granted port's done and rdata SHALL stay 0.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force state=IDLE, last_grant=instruction (so the first conflict grants data), counter=0, and all outputs to 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction without a done pulse; a late mem_done after reset is ignored under REQ-018.

Structure
REQ-027 A shared package wisc_mem_pkg SHALL hold the FSM state enum (IDLE/ISSUE/WAIT), the grant enum (GNT_I/GNT_D) and the default TIMEOUT constant.
REQ-028 The round-robin choice SHALL be a sub-module rr_arb2 (inputs req[1:0] and last; output gnt); the FSM and datapath latches stay in mem_arbiter.

Verification
REQ-029 Scenario: single fetch i_addr=0x0040, backend returns 0xBEEF after 1 cycle -> mem_rd for 1 cycle with mem_addr=0x0040; i_done pulse with i_rdata=0xBEEF at N+3; d_done stays 0.
REQ-030 Scenario: simultaneous i_req and d_req right after reset, held for two transactions -> data granted first, then instruction; exactly one done per port.
REQ-031 Scenario: store d_addr=0x1000, d_wdata=0x1234, mem_stall=1 for 3 cycles -> mem_wr held 4 cycles with stable address/data; d_done pulses once with d_rdata=0.
REQ-032 Scenario: TIMEOUT=8 and mem_done never arrives -> err and the granted done pulse together exactly 8 WAIT cycles after entry; FSM returns to IDLE.
REQ-033 Scenario: rst asserted during WAIT, then mem_done pulses after rst is released -> no done pulse; all outputs 0; the next request is serviced normally.
